// File: rtl/mult_div_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operation
// select values and the controller state enumeration.
package mult_div_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } mdOp_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } mdState_e;

endpackage

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit: one product/quotient bit per cycle on operand
// magnitudes, with sign correction applied in a final FIX cycle.
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             abort,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    mdState_e             state;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     bMag;
    logic                 isDiv;
    logic                 signA;
    logic                 signB;
    logic [CNT_W-1:0]     cnt;

    logic                 reqSigned;
    logic                 reqDiv;
    logic                 reqDivZero;
    logic [WIDTH-1:0]     aMagIn;
    logic [WIDTH-1:0]     bMagIn;

    always_comb begin
        reqSigned  = (op == OP_MULT) || (op == OP_DIV);
        reqDiv     = (op == OP_DIV) || (op == OP_DIVU);
        reqDivZero = reqDiv && (b == '0);
        aMagIn     = (reqSigned && a[WIDTH-1]) ? -a : a;
        bMagIn     = (reqSigned && b[WIDTH-1]) ? -b : b;
    end

    // One iteration step. Multiply: add-and-shift-right with carry into the
    // top. Divide: shift left, then keep the trial subtraction if it didn't
    // borrow; the partial remainder needs WIDTH+1 bits right after the shift.
    logic [WIDTH:0]       mulSum;
    logic [WIDTH:0]       divRem;
    logic [WIDTH:0]       divDiff;
    logic [2*WIDTH-1:0]   accNext;

    always_comb begin
        mulSum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, bMag} : '0);
        divRem  = acc[2*WIDTH-1:WIDTH-1];
        divDiff = divRem - {1'b0, bMag};
        if (isDiv) begin
            if (!divDiff[WIDTH])
                accNext = {divDiff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else
                accNext = {divRem[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end else begin
            accNext = {mulSum, acc[WIDTH-1:1]};
        end
    end

    // Sign fix-up; signs are captured as 0 for unsigned ops.
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH-1:0]     quo;
    logic [WIDTH-1:0]     rem;

    always_comb begin
        prod = (signA ^ signB) ? -acc : acc;
        quo  = (signA ^ signB) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem  = signA ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            acc      <= '0;
            bMag     <= '0;
            isDiv    <= 1'b0;
            signA    <= 1'b0;
            signB    <= 1'b0;
            cnt      <= '0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        if (reqDivZero) begin
                            done     <= 1'b1;
                            div_zero <= 1'b1;
                        end else begin
                            state <= CALC;
                            acc   <= {{WIDTH{1'b0}}, aMagIn};
                            bMag  <= bMagIn;
                            isDiv <= reqDiv;
                            signA <= reqSigned && a[WIDTH-1];
                            signB <= reqSigned && b[WIDTH-1];
                            cnt   <= '0;
                        end
                    end
                end
                CALC: begin
                    if (abort) begin
                        state <= IDLE;
                    end else begin
                        acc <= accNext;
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_W'(WIDTH - 1))
                            state <= FIX;
                    end
                end
                FIX: begin
                    if (!abort) begin
                        if (isDiv) begin
                            hi <= rem;
                            lo <= quo;
                        end else begin
                            hi <= prod[2*WIDTH-1:WIDTH];
                            lo <= prod[WIDTH-1:0];
                        end
                        done <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width; legal values are 8 to 64, even.
REQ-002 The block SHALL have parameter CNT_W, default $clog2(WIDTH+1), giving the iteration counter width.
REQ-003 The block SHALL have port clk, input, width 1: the single clock; all state changes on the rising edge.
REQ-004 The block SHALL have port reset, input, width 1: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, width 1: operation request, sampled only in IDLE.
REQ-006 The block SHALL have port op, input, width 2: operation select. 00 = MULT (signed), 01 = MULTU, 10 = DIV (signed), 11 = DIVU.
REQ-007 The block SHALL have ports a and b, input, width WIDTH: multiplicand/multiplier, or dividend/divisor.
REQ-008 The block SHALL have port abort, input, width 1: exception flush.
REQ-009 The block SHALL have ports hi and lo, output, width WIDTH: the result registers.
REQ-010 The block SHALL have port busy, output, width 1: operation in progress.
REQ-011 The block SHALL have port done, output, width 1: one-cycle completion pulse.
REQ-012 The block SHALL have port div_zero, output, width 1: one-cycle divide-by-zero flag, coincident with done.

Function
REQ-013 The FSM SHALL have three states:
- IDLE
- CALC: iterating, one quotient/product bit per cycle
- FIX: sign correction and result write
REQ-014 IDLE SHALL go to CALC on the edge E0 where start=1 and the operation is not DIV/DIVU with b=0. At E0 the block captures the operand magnitudes and sign bits and clears the counter.
REQ-015 The multiply path SHALL use shift-add on magnitudes and produce a 2*WIDTH product. Signed ops SHALL negate the product in FIX when the operand signs differ.
REQ-016 The divide path SHALL use restoring division on magnitudes.
- Quotient truncates toward zero.
- Remainder takes the dividend's sign.
REQ-017 CALC SHALL perform exactly WIDTH iterations on edges E1..E(WIDTH), then enter FIX.
REQ-018 FIX SHALL, on edge E(WIDTH+1):
- write hi/lo: MULT gives hi = upper half, lo = lower half; DIV gives lo = quotient, hi = remainder;
- pulse done=1 for the following cycle;
- return to IDLE.
REQ-019 busy SHALL equal (state != IDLE). busy is high for WIDTH+1 cycles and is low in the done cycle.
REQ-020 A start SHALL be accepted in the done cycle (back-to-back operation).
REQ-021 DIV/DIVU with b=0 at E0 SHALL:
- stay in IDLE;
- assert done=1 and div_zero=1 for the next cycle;
- leave hi/lo unchanged.
REQ-022 Signed DIV of most-negative by -1 SHALL give lo = most-negative (wrap) and hi = 0, with no flag.
REQ-023 start while busy SHALL be ignored, with no queuing.
REQ-024 abort=1 in CALC or FIX SHALL return the FSM to IDLE on the next edge, with no done and hi/lo unchanged. abort SHALL have priority over FIX completion. abort in IDLE SHALL have priority over start.
REQ-025 hi/lo SHALL change only on FIX completion and SHALL hold otherwise.
REQ-026 div_zero SHALL be 0 whenever done is 0.

Reset
REQ-027 While reset=0, asynchronously:
- state = IDLE;
- hi, lo, counter and internal datapath registers = 0;
- busy = done = div_zero = 0.
REQ-028 Reset mid-operation SHALL discard the operation; no done follows reset release.

Structure
REQ-029 Package mult_div_pkg SHALL hold the op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU) and the FSM state enumeration.
REQ-030 The block SHALL be implemented as a single module, with no sub-modules. Multiply and divide SHALL share one 2*WIDTH accumulator/remainder register.

Verification (WIDTH=32)
REQ-031 MULT a=0xFFFFFFFE, b=3 -> done in cycle after edge 33; hi=0xFFFFFFFF, lo=0xFFFFFFFA; busy high 33 cycles.
REQ-032 DIVU a=100, b=7 -> lo=14, hi=2. DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-033 DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0.
REQ-034 DIVU b=0 with prior hi/lo = 0x1234/0x5678 -> done and div_zero both high in the cycle after E0; hi/lo unchanged; busy never high.
REQ-035 MULTU 0xFFFFFFFF x 0xFFFFFFFF started in the done cycle of the previous op -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-036 abort at edge E10, and separately reset=0 at E10 -> no done pulse; hi/lo unchanged (abort) or zero (reset). A following MULT 6x7 gives lo=42.
